// File: rtl/eth_rx_framer.sv
// Byte-wide Ethernet receive framer: strips preamble/SFD, emits frame bytes as a stream with 2-cycle latency.
// Optional FCS check enabled by defining ETH_RX_FCS_CHECK_EN.
module eth_rx_framer #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic       clk_125,
   input  logic       rst,
   input  logic       rx_en,
   input  logic [7:0] rx_data,
   input  logic       rx_dv,
   input  logic       rx_er,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   output logic       m_tlast,
   output logic       m_tuser,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       pre_err
);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   localparam logic [15:0] MIN_CNT = 16'(MIN_LEN);
   localparam logic [15:0] MAX_CNT = 16'(MAX_LEN);

   state_t      r_state;
   state_t      w_state_next;
   logic        r_dv_prev;
   logic [7:0]  r_hold;
   logic [15:0] r_cnt;
   logic        r_err;

   logic [7:0]  r_tdata;
   logic        r_tvalid;
   logic        r_tlast;
   logic        r_tuser;
   logic        r_ok;
   logic        r_ferr;
   logic        r_pre;

   logic [7:0]  w_tdata_next;
   logic        w_tvalid_next;
   logic        w_tlast_next;
   logic        w_tuser_next;
   logic        w_ok_next;
   logic        w_ferr_next;
   logic        w_pre_next;
   logic        w_hold_load;
   logic        w_clear;
   logic        w_err_set;
   logic        w_have;
   logic        w_bad;
   logic        w_crc_bad;

`ifdef ETH_RX_FCS_CHECK_EN
   logic [31:0] r_crc;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] v;
      v = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++)
         v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      return v;
   endfunction

   // CRC over data plus FCS leaves the fixed residue when the frame is intact
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst)
         r_crc <= 32'hFFFFFFFF;
      else if (w_clear)
         r_crc <= 32'hFFFFFFFF;
      else if (w_hold_load)
         r_crc <= crc_byte(r_crc, rx_data);
   end

   assign w_crc_bad = (r_crc != 32'hDEBB20E3);
`else
   assign w_crc_bad = 1'b0;
`endif

   assign w_have = (r_cnt != 16'h0000);
   assign w_bad  = r_err | (r_cnt < MIN_CNT) | w_crc_bad;

   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next  = r_state;
      w_tdata_next  = 8'h00;
      w_tvalid_next = 1'b0;
      w_tlast_next  = 1'b0;
      w_tuser_next  = 1'b0;
      w_ok_next     = 1'b0;
      w_ferr_next   = 1'b0;
      w_pre_next    = 1'b0;
      w_hold_load   = 1'b0;
      w_clear       = 1'b0;
      w_err_set     = 1'b0;
      case (r_state)
         IDLE: begin
            if (rx_dv) begin
               if (r_dv_prev) begin
                  w_state_next = DROP;
               end else begin
                  w_clear = 1'b1;
                  if (!rx_en)
                     w_state_next = DROP;
                  else if (rx_data == 8'h55)
                     w_state_next = PREAMBLE;
                  else if (rx_data == 8'hD5)
                     w_state_next = DATA;
                  else begin
                     w_state_next = DROP;
                     w_pre_next   = 1'b1;
                  end
               end
            end
         end
         PREAMBLE: begin
            if (!rx_dv) begin
               w_state_next = IDLE;
               w_pre_next   = 1'b1;
            end else begin
               w_err_set = rx_er;
               if (rx_data == 8'hD5)
                  w_state_next = DATA;
               else if (rx_data != 8'h55) begin
                  w_state_next = DROP;
                  w_pre_next   = 1'b1;
               end
            end
         end
         DATA: begin
            if (rx_dv) begin
               if (r_cnt == MAX_CNT) begin
                  // Oversize: close the frame on byte MAX_LEN and discard the rest
                  w_tvalid_next = 1'b1;
                  w_tdata_next  = r_hold;
                  w_tlast_next  = 1'b1;
                  w_tuser_next  = 1'b1;
                  w_ferr_next   = 1'b1;
                  w_state_next  = DROP;
               end else begin
                  w_hold_load = 1'b1;
                  w_err_set   = rx_er;
                  if (w_have) begin
                     w_tvalid_next = 1'b1;
                     w_tdata_next  = r_hold;
                  end
               end
            end else begin
               w_state_next = IDLE;
               if (w_have) begin
                  w_tvalid_next = 1'b1;
                  w_tdata_next  = r_hold;
                  w_tlast_next  = 1'b1;
                  w_tuser_next  = w_bad;
                  w_ok_next     = !w_bad;
                  w_ferr_next   = w_bad;
               end else begin
                  w_pre_next = 1'b1;
               end
            end
         end
         DROP: begin
            if (!rx_dv)
               w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst) begin
         r_dv_prev <= 1'b0;
         r_hold    <= 8'h00;
         r_cnt     <= 16'h0000;
         r_err     <= 1'b0;
         r_tdata   <= 8'h00;
         r_tvalid  <= 1'b0;
         r_tlast   <= 1'b0;
         r_tuser   <= 1'b0;
         r_ok      <= 1'b0;
         r_ferr    <= 1'b0;
         r_pre     <= 1'b0;
      end else begin
         r_dv_prev <= rx_dv;
         if (w_hold_load)
            r_hold <= rx_data;
         if (w_clear)
            r_cnt <= 16'h0000;
         else if (w_hold_load && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'h0001;
         if (w_clear)
            r_err <= 1'b0;
         else if (w_err_set)
            r_err <= 1'b1;
         r_tdata  <= w_tdata_next;
         r_tvalid <= w_tvalid_next;
         r_tlast  <= w_tlast_next;
         r_tuser  <= w_tuser_next;
         r_ok     <= w_ok_next;
         r_ferr   <= w_ferr_next;
         r_pre    <= w_pre_next;
      end
   end

   assign m_tdata   = r_tdata;
   assign m_tvalid  = r_tvalid;
   assign m_tlast   = r_tlast;
   assign m_tuser   = r_tuser;
   assign frame_ok  = r_ok;
   assign frame_err = r_ferr;
   assign pre_err   = r_pre;

endmodule

// File: tb/tb_eth_rx_framer.sv
// Scoreboard bench for eth_rx_framer: expected beats queued as bytes are driven, compared as the DUT emits them.
module tb_eth_rx_framer;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_en = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_dv = 1'b0;
   logic       rx_er = 1'b0;
   logic [7:0] m_tdata;
   logic       m_tvalid, m_tlast, m_tuser, frame_ok, frame_err, pre_err;

   eth_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
      .clk_125(clk), .rst(rst), .rx_en(rx_en), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
      .frame_ok(frame_ok), .frame_err(frame_err), .pre_err(pre_err)
   );

   always #4 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         last;
      bit         user;
      int         cyc;
   } beat_t;

   beat_t      sb[$];
   beat_t      e;
   beat_t      b;
   int         cyc = 0;
   int         pre_cnt = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   logic [7:0] frm [0:1999];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference FCS: CRC-32 over the first n-4 bytes, complemented, sent LSB first
   function automatic logic [31:0] fcs_of(input int nbytes);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < nbytes; i++) begin
         c = c ^ {24'h0, frm[i]};
         for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic bit fcs_good(input int n);
      if (n < 4) return 1'b0;
      return {frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == fcs_of(n - 4);
   endfunction

   // mode 0: counting bytes; 1: counting bytes + valid FCS; 2: as 1 with last FCS byte corrupted
   task automatic fill(input int n, input int mode);
      logic [31:0] f;
      for (int i = 0; i < n; i++) frm[i] = 8'(i);
      if (mode != 0 && n >= 4) begin
         f = fcs_of(n - 4);
         frm[n-4] = f[7:0];
         frm[n-3] = f[15:8];
         frm[n-2] = f[23:16];
         frm[n-1] = f[31:24];
         if (mode == 2) frm[n-1] = frm[n-1] ^ 8'h01;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (m_tvalid) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", 32'(m_tdata), 32'hFFFFFFFF);
            end else begin
               e = sb.pop_front();
               $display("beat data=%02h last=%0b user=%0b cycle=%0d", m_tdata, m_tlast, m_tuser, cyc);
               check("tdata", 32'(m_tdata), 32'(e.d));
               check("latency", 32'(cyc), 32'(e.cyc));
               check("tlast", 32'(m_tlast), 32'(e.last));
               if (e.last) check("tuser", 32'(m_tuser), 32'(e.user));
               check("frame_ok", 32'(frame_ok), 32'(e.last && !e.user));
               check("frame_err", 32'(frame_err), 32'(e.last && e.user));
            end
         end else begin
            check("idle_outputs", 32'({m_tdata, m_tlast, frame_ok, frame_err}), 32'h0);
         end
         if (pre_err) pre_cnt++;
      end
   end

   task automatic send_frame(input int n, input int npre, input bit en, input bit bad_pre,
                             input int er_idx, input int abort_at);
      int outn;
      bit u;
      bit aborted;
      int exp_pre;
      outn = (n > MAX_LEN) ? MAX_LEN : n;
      u = (er_idx >= 0 && er_idx < outn) || (n < MIN_LEN) || (n > MAX_LEN);
`ifdef ETH_RX_FCS_CHECK_EN
      if (n <= MAX_LEN && !fcs_good(n)) u = 1'b1;
`endif
      exp_pre = pre_cnt + ((en && (bad_pre || n == 0)) ? 1 : 0);
      aborted = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
      end
      rx_en = en;
      for (int k = 0; k < npre; k++) begin
         tick();
         rx_dv = 1'b1; rx_data = 8'h55;
      end
      tick();
      rx_dv = 1'b1;
      rx_data = bad_pre ? 8'h12 : 8'hD5;
      for (int i = 0; i < n; i++) begin
         tick();
         if (i == abort_at) begin
            aborted = 1'b1;
            break;
         end
         rx_data = frm[i];
         rx_er = (i == er_idx);
         if (en && !bad_pre && i < outn && (abort_at < 0 || i <= abort_at - 3)) begin
            b.d = frm[i];
            b.last = (abort_at < 0) && (i == outn - 1);
            b.user = b.last && u;
            b.cyc = cyc + 2;
            sb.push_back(b);
         end
      end
      if (aborted) begin
         rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_outputs", 32'({m_tdata, m_tvalid, m_tlast, m_tuser, frame_ok, frame_err, pre_err}), 32'h0);
         end
         tick();
         rst = 1'b0;
      end else begin
         tick();
         rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
      end
      for (int k = 0; k < 8; k++) tick();
      check("sb_drained", 32'(sb.size()), 32'h0);
      sb.delete();
      check("pre_err_count", 32'(pre_cnt), 32'(exp_pre));
      $display("frame n=%0d pre=%0d en=%0b badpre=%0b er=%0d abort=%0d done at cycle %0d",
               n, npre, en, bad_pre, er_idx, abort_at, cyc);
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({m_tdata, m_tvalid, m_tlast, m_tuser, frame_ok, frame_err, pre_err}), 32'h0);
      tick();
      rst = 1'b0;

      fill(64, 0);   send_frame(64, 7, 1'b1, 1'b0, -1, -1);  // nominal 0x00..0x3F
      fill(64, 0);   send_frame(64, 7, 1'b1, 1'b0, 10, -1);  // rx_er on byte 10
      fill(10, 0);   send_frame(10, 2, 1'b1, 1'b1, -1, -1);  // 55 55 12 preamble
      fill(64, 1);   send_frame(64, 7, 1'b1, 1'b0, -1, -1);  // valid FCS
      fill(64, 2);   send_frame(64, 7, 1'b1, 1'b0, -1, -1);  // corrupted FCS
      fill(1600, 0); send_frame(1600, 7, 1'b1, 1'b0, -1, -1);
      fill(1518, 0); send_frame(1518, 7, 1'b1, 1'b0, -1, -1);
      fill(1519, 0); send_frame(1519, 7, 1'b1, 1'b0, -1, -1);
      fill(63, 0);   send_frame(63, 7, 1'b1, 1'b0, -1, -1);
      fill(40, 0);   send_frame(40, 7, 1'b1, 1'b0, -1, -1);
      fill(64, 0);   send_frame(64, 7, 1'b0, 1'b0, -1, -1);  // rx_en low
      send_frame(0, 7, 1'b1, 1'b0, -1, -1);                  // SFD then rx_dv drop
      fill(64, 0);   send_frame(64, 0, 1'b1, 1'b0, -1, -1);  // SFD without preamble
      fill(40, 0);   send_frame(40, 7, 1'b1, 1'b0, -1, 20);  // reset mid-frame
      fill(64, 1);   send_frame(64, 7, 1'b1, 1'b0, -1, -1);  // recovery after reset

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
